// File: rtl/mux3_rr_sel_gen_if.sv
// Request/enable inputs and grant/select outputs of the round-robin select generator.
interface mux3_rr_sel_gen_if #(
    parameter int CNT_W = 4
);
    logic [2:0]       req;
    logic             en;
    logic [1:0]       sel;
    logic [2:0]       gnt;
    logic             busy;
    logic [CNT_W-1:0] burst_cnt;

    modport master (
        output req, en,
        input  sel, gnt, busy, burst_cnt
    );

    modport slave (
        input  req, en,
        output sel, gnt, busy, burst_cnt
    );
endinterface

// File: rtl/mux3_rr_sel_gen.sv
// Round-robin arbiter over sources a/b/c with bounded bursts; drives the 2-bit
// select of the downstream 3:1 mux (select 00 forces the mux output to zero).
module mux3_rr_sel_gen #(
    parameter int MAX_BURST = 4,
    parameter int CNT_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mux3_rr_sel_gen_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_A    = 2'b11;
    localparam logic [1:0] SRC_B    = 2'b10;
    localparam logic [1:0] SRC_C    = 2'b01;

    state_e           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       nxtFromPtr;
    logic [1:0]       nxtFromSel;
    logic             curReq;

    // Successor in rotation order a -> b -> c -> a.
    function automatic logic [1:0] succSrc(input logic [1:0] src);
        logic [1:0] s;
        case (src)
            SRC_A:   s = SRC_B;
            SRC_B:   s = SRC_C;
            default: s = SRC_A;
        endcase
        return s;
    endfunction

    function automatic logic reqOf(input logic [2:0] req, input logic [1:0] src);
        logic r;
        case (src)
            SRC_A:   r = req[2];
            SRC_B:   r = req[1];
            SRC_C:   r = req[0];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // The source after 'after' is searched first and 'after' itself last, so a
    // lone persistent requester is re-granted without a bubble.
    function automatic logic [1:0] nextSrc(input logic [2:0] req, input logic [1:0] after);
        logic [1:0] c1, c2, c3, res;
        c1 = succSrc(after);
        c2 = succSrc(c1);
        c3 = succSrc(c2);
        if (reqOf(req, c1))      res = c1;
        else if (reqOf(req, c2)) res = c2;
        else if (reqOf(req, c3)) res = c3;
        else                     res = SRC_NONE;
        return res;
    endfunction

    function automatic logic [2:0] decodeGnt(input logic [1:0] src);
        logic [2:0] g;
        case (src)
            SRC_A:   g = 3'b100;
            SRC_B:   g = 3'b010;
            SRC_C:   g = 3'b001;
            default: g = 3'b000;
        endcase
        return g;
    endfunction

    assign nxtFromPtr = nextSrc(bus.req, ptr_q);
    assign nxtFromSel = nextSrc(bus.req, sel_q);
    assign curReq     = reqOf(bus.req, sel_q);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (bus.en) begin
            case (state_q)
                IDLE: begin
                    if (nxtFromPtr != SRC_NONE) begin
                        state_d = GRANT;
                        sel_d   = nxtFromPtr;
                        ptr_d   = nxtFromPtr;
                        cnt_d   = CNT_W'(1);
                    end
                end
                GRANT: begin
                    if (curReq && (cnt_q < CNT_W'(MAX_BURST))) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (nxtFromSel != SRC_NONE) begin
                        sel_d = nxtFromSel;
                        ptr_d = nxtFromSel;
                        cnt_d = CNT_W'(1);
                    end else begin
                        state_d = IDLE;
                        sel_d   = SRC_NONE;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = SRC_NONE;
                    cnt_d   = '0;
                end
            endcase
        end
        gnt_d = decodeGnt(sel_d);
    end

    // Reset restores the pointer to c so that a wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= SRC_NONE;
            gnt_q   <= 3'b000;
            ptr_q   <= SRC_C;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.gnt       = gnt_q;
    assign bus.busy      = (state_q == GRANT);
    assign bus.burst_cnt = cnt_q;

endmodule

// File: tb/tb_mux3_rr_sel_gen.sv
// Scoreboard bench: two arbiters (MAX_BURST 4 and 1) share stimulus and are
// compared against an index-based round-robin reference model.
module tb_mux3_rr_sel_gen;

    localparam int CW = 4;

    typedef struct {
        int sel;
        int gnt;
        int busy;
        int cnt;
        int muxOut;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] reqDrv;
    logic       enDrv;
    logic [7:0] dataArr [3];

    int   errors = 0;
    int   checks = 0;
    exp_t q0[$];
    exp_t q1[$];

    int curIdx  [2];
    int lastIdx [2];
    int cnt     [2];
    int maxB    [2] = '{4, 1};

    mux3_rr_sel_gen_if #(.CNT_W(CW)) bus4 ();
    mux3_rr_sel_gen_if #(.CNT_W(CW)) bus1 ();

    assign bus4.req = reqDrv;
    assign bus4.en  = enDrv;
    assign bus1.req = reqDrv;
    assign bus1.en  = enDrv;

    mux3_rr_sel_gen #(.MAX_BURST(4), .CNT_W(CW)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    mux3_rr_sel_gen #(.MAX_BURST(1), .CNT_W(CW)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    // Behavioural 3:1 mux fed by the DUT select: 11=a, 10=b, 01=c, 00 -> 0.
    function automatic int muxOf(input logic [1:0] s);
        case (s)
            2'b11:   return int'(dataArr[0]);
            2'b10:   return int'(dataArr[1]);
            2'b01:   return int'(dataArr[2]);
            default: return 0;
        endcase
    endfunction

    task automatic checkField(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            curIdx[k]  = -1;
            lastIdx[k] = 2;
            cnt[k]     = 0;
        end
    endtask

    // Sources indexed a=0, b=1, c=2; request bit for index i is req[2-i].
    task automatic modelStep(input int k, input logic [2:0] r, input logic e);
        int pick;
        int base;
        pick = -1;
        if (!e) return;
        if (curIdx[k] >= 0 && r[2-curIdx[k]] && cnt[k] < maxB[k]) begin
            cnt[k]++;
            return;
        end
        base = (curIdx[k] >= 0) ? curIdx[k] : lastIdx[k];
        for (int s = 1; s <= 3; s++) begin
            int idx;
            idx = (base + s) % 3;
            if (pick < 0 && r[2-idx]) pick = idx;
        end
        if (pick < 0) begin
            curIdx[k] = -1;
            cnt[k]    = 0;
        end else begin
            curIdx[k]  = pick;
            lastIdx[k] = pick;
            cnt[k]     = 1;
        end
    endtask

    function automatic exp_t modelExpect(input int k);
        exp_t e;
        if (curIdx[k] < 0) begin
            e.sel = 0; e.gnt = 0; e.busy = 0; e.cnt = 0; e.muxOut = 0;
        end else begin
            e.sel    = 3 - curIdx[k];
            e.gnt    = 4 >> curIdx[k];
            e.busy   = 1;
            e.cnt    = cnt[k];
            e.muxOut = int'(dataArr[curIdx[k]]);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic [2:0] r, input logic e);
        @(negedge clk);
        reqDrv = r;
        enDrv  = e;
        modelStep(0, r, e);
        modelStep(1, r, e);
        q0.push_back(modelExpect(0));
        q1.push_back(modelExpect(1));
    endtask

    task automatic checkOutput(input int k, input exp_t e);
        string tag;
        tag = (k == 0) ? "mb4" : "mb1";
        if (k == 0) begin
            checkField({tag, ".sel"},  int'(bus4.sel),       e.sel);
            checkField({tag, ".gnt"},  int'(bus4.gnt),       e.gnt);
            checkField({tag, ".busy"}, int'(bus4.busy),      e.busy);
            checkField({tag, ".cnt"},  int'(bus4.burst_cnt), e.cnt);
            checkField({tag, ".mux"},  muxOf(bus4.sel),      e.muxOut);
        end else begin
            checkField({tag, ".sel"},  int'(bus1.sel),       e.sel);
            checkField({tag, ".gnt"},  int'(bus1.gnt),       e.gnt);
            checkField({tag, ".busy"}, int'(bus1.busy),      e.busy);
            checkField({tag, ".cnt"},  int'(bus1.burst_cnt), e.cnt);
            checkField({tag, ".mux"},  muxOf(bus1.sel),      e.muxOut);
        end
    endtask

    task automatic checkIdleNow(input string name);
        checkField({name, ".mb4.sel"},  int'(bus4.sel),       0);
        checkField({name, ".mb4.gnt"},  int'(bus4.gnt),       0);
        checkField({name, ".mb4.busy"}, int'(bus4.busy),      0);
        checkField({name, ".mb4.cnt"},  int'(bus4.burst_cnt), 0);
        checkField({name, ".mb1.sel"},  int'(bus1.sel),       0);
        checkField({name, ".mb1.busy"}, int'(bus1.busy),      0);
    endtask

    // Asynchronous reset between edges; requests are parked at zero while
    // reset is released so the first post-reset edge sees an idle arbiter.
    task automatic resetMidGrant();
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        reqDrv = 3'b000;
        #1;
        checkIdleNow("async_rst");
        q0.delete();
        q1.delete();
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every cycle the DUT presents registered outputs, popped and compared.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q0.size() > 0) checkOutput(0, q0.pop_front());
            if (q1.size() > 0) checkOutput(1, q1.pop_front());
        end
    end

    initial begin
        dataArr[0] = 8'($urandom_range(1, 255));
        dataArr[1] = 8'($urandom_range(1, 255));
        dataArr[2] = 8'($urandom_range(1, 255));
        rst_n  = 1'b0;
        reqDrv = 3'b000;
        enDrv  = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkIdleNow("reset");
        rst_n = 1'b1;

        repeat (10) applyStimulus(3'b010, 1'b1);
        repeat (2)  applyStimulus(3'b000, 1'b1);

        repeat (16) applyStimulus(3'b111, 1'b1);
        repeat (2)  applyStimulus(3'b000, 1'b1);

        repeat (2) applyStimulus(3'b010, 1'b1);
        applyStimulus(3'b001, 1'b1);
        applyStimulus(3'b000, 1'b1);
        applyStimulus(3'b000, 1'b1);

        repeat (3) applyStimulus(3'b100, 1'b1);
        repeat (5) applyStimulus(3'($urandom_range(0, 7)), 1'b0);
        repeat (2) applyStimulus(3'b110, 1'b1);
        repeat (2) applyStimulus(3'b000, 1'b1);

        repeat (6) applyStimulus(3'b101, 1'b1);

        repeat (2) applyStimulus(3'b111, 1'b1);
        resetMidGrant();
        repeat (3) applyStimulus(3'b111, 1'b1);

        for (int i = 0; i < 400; i++) begin
            applyStimulus(3'($urandom_range(0, 7)), ($urandom_range(0, 9) != 0));
        end

        repeat (3) @(posedge clk);
        #2;
        checkField("scoreboard_drain", q0.size() + q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
